alu_arbiter: RTL and testbench

//  Shares the single combinational ALU between two requesters: req0 = control-unit microsequencer, req1 = trap/debug unit.
//  Per operation: accepts operands and func, drives the ALU for one cycle, registers busC, then returns the result.

---
 rtl/arc_alu_pkg.sv | 40 ++++
 rtl/alu_rr_pick.sv | 16 +
 rtl/alu_arbiter.sv | 159 +++++++++++++++
 tb/tb_alu_arbiter.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/arc_alu_pkg.sv
// Shared definitions for the ARC ALU datapath: func codes, PSR bit positions
// and the arbiter state encoding.
package arc_alu_pkg;

   localparam logic [3:0] F_ANDCC   = 4'd0;
   localparam logic [3:0] F_ORCC    = 4'd1;
   localparam logic [3:0] F_NORCC   = 4'd2;
   localparam logic [3:0] F_ADDCC   = 4'd3;
   localparam logic [3:0] F_SRL     = 4'd4;
   localparam logic [3:0] F_AND     = 4'd5;
   localparam logic [3:0] F_OR      = 4'd6;
   localparam logic [3:0] F_NOR     = 4'd7;
   localparam logic [3:0] F_ADD     = 4'd8;
   localparam logic [3:0] F_LSHIFT2 = 4'd9;
   localparam logic [3:0] F_LSHIFT10 = 4'd10;
   localparam logic [3:0] F_SIMM13  = 4'd11;
   localparam logic [3:0] F_SEXT13  = 4'd12;
   localparam logic [3:0] F_INC     = 4'd13;
   localparam logic [3:0] F_INCPC   = 4'd14;
   localparam logic [3:0] F_RSHIFT5 = 4'd15;

   // Condition-code ops occupy the bottom of the func space.
   localparam logic [3:0] CC_MAXFUNC = F_ADDCC;

   localparam int PSR_N = 3;
   localparam int PSR_Z = 2;
   localparam int PSR_V = 1;
   localparam int PSR_C = 0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } arb_state_e;

   function automatic logic is_cc_func(input logic [3:0] func, input logic [3:0] max_func);
      return func <= max_func;
   endfunction

endpackage

// File: rtl/alu_rr_pick.sv
// Two-way round-robin grant: a lone requester always wins, a tie goes to the
// side named by ptr.
module alu_rr_pick (
   input  logic [1:0] valid,
   input  logic       ptr,
   output logic [1:0] gnt
);

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_gnt
         assign gnt[gi] = valid[gi] & (~valid[1-gi] | (ptr == 1'(gi)));
      end
   endgenerate

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between the microsequencer (req0) and the
// trap/debug unit (req1); owns the architectural PSR.
module alu_arbiter #(
   parameter int         W          = 32,
   parameter logic [3:0] PSR_RST    = 4'b0000,
   parameter logic [3:0] CC_MAXFUNC = arc_alu_pkg::CC_MAXFUNC
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         req0_valid,
   output logic         req0_ready,
   input  logic [W-1:0] req0_a,
   input  logic [W-1:0] req0_b,
   input  logic [3:0]   req0_func,
   input  logic         req1_valid,
   output logic         req1_ready,
   input  logic [W-1:0] req1_a,
   input  logic [W-1:0] req1_b,
   input  logic [3:0]   req1_func,
   output logic         rsp0_valid,
   input  logic         rsp0_ready,
   output logic         rsp1_valid,
   input  logic         rsp1_ready,
   output logic [W-1:0] rsp_c,
   output logic [W-1:0] alu_a,
   output logic [W-1:0] alu_b,
   output logic [3:0]   alu_func,
   input  logic [W-1:0] alu_c,
   input  logic [3:0]   alu_psr,
   output logic [3:0]   psr,
   output logic         psr_upd,
   output logic         busy
);

   import arc_alu_pkg::*;

   arb_state_e   state_q, state_d;
   logic         rr_ptr_q, rr_ptr_d;
   logic         owner_q, owner_d;
   logic [W-1:0] op_a_q, op_a_d;
   logic [W-1:0] op_b_q, op_b_d;
   logic [3:0]   op_func_q, op_func_d;
   logic [W-1:0] rsp_c_q, rsp_c_d;
   logic [3:0]   psr_q, psr_d;
   logic         psr_upd_q, psr_upd_d;

   logic [1:0]   req_valid;
   logic [1:0]   gnt;
   logic [1:0]   req_ready_c;
   logic [1:0]   rsp_valid_c;
   logic [1:0]   rsp_ready;
   logic [W-1:0] sel_a, sel_b;
   logic [3:0]   sel_func;
   logic [W-1:0] alu_a_c, alu_b_c;
   logic [3:0]   alu_func_c;

   assign req_valid = {req1_valid, req0_valid};
   assign rsp_ready = {rsp1_ready, rsp0_ready};

   alu_rr_pick u_pick (
      .valid (req_valid),
      .ptr   (rr_ptr_q),
      .gnt   (gnt)
   );

   // The picker yields at most one grant, so gnt[1] alone selects the operands.
   assign sel_a    = gnt[1] ? req1_a    : req0_a;
   assign sel_b    = gnt[1] ? req1_b    : req0_b;
   assign sel_func = gnt[1] ? req1_func : req0_func;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         rr_ptr_q  <= 1'b0;
         owner_q   <= 1'b0;
         op_a_q    <= '0;
         op_b_q    <= '0;
         op_func_q <= '0;
         rsp_c_q   <= '0;
         psr_q     <= PSR_RST;
         psr_upd_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         rr_ptr_q  <= rr_ptr_d;
         owner_q   <= owner_d;
         op_a_q    <= op_a_d;
         op_b_q    <= op_b_d;
         op_func_q <= op_func_d;
         rsp_c_q   <= rsp_c_d;
         psr_q     <= psr_d;
         psr_upd_q <= psr_upd_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      owner_d     = owner_q;
      op_a_d      = op_a_q;
      op_b_d      = op_b_q;
      op_func_d   = op_func_q;
      rsp_c_d     = rsp_c_q;
      psr_d       = psr_q;
      psr_upd_d   = 1'b0;
      req_ready_c = 2'b00;
      rsp_valid_c = 2'b00;
      alu_a_c     = '0;
      alu_b_c     = '0;
      alu_func_c  = '0;

      case (state_q)
         IDLE: begin
            if (|req_valid) begin
               req_ready_c = gnt;
               owner_d     = gnt[1];
               op_a_d      = sel_a;
               op_b_d      = sel_b;
               op_func_d   = sel_func;
               state_d     = EXEC;
            end
         end
         EXEC: begin
            alu_a_c    = op_a_q;
            alu_b_c    = op_b_q;
            alu_func_c = op_func_q;
            rsp_c_d    = alu_c;
            if (is_cc_func(op_func_q, CC_MAXFUNC)) begin
               psr_d     = alu_psr;
               psr_upd_d = 1'b1;
            end
            state_d = RESP;
         end
         RESP: begin
            rsp_valid_c = owner_q ? 2'b10 : 2'b01;
            // Fairness: the other side gets the tie-break after each completed op.
            if (rsp_ready[owner_q]) begin
               state_d  = IDLE;
               rr_ptr_d = ~owner_q;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign req0_ready = req_ready_c[0];
   assign req1_ready = req_ready_c[1];
   assign rsp0_valid = rsp_valid_c[0];
   assign rsp1_valid = rsp_valid_c[1];
   assign rsp_c      = rsp_c_q;
   assign alu_a      = alu_a_c;
   assign alu_b      = alu_b_c;
   assign alu_func   = alu_func_c;
   assign psr        = psr_q;
   assign psr_upd    = psr_upd_q;
   assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed scoreboard bench for alu_arbiter with a behavioural ARC ALU
// attached to the alu_* ports.
module tb_alu_arbiter;
   import arc_alu_pkg::*;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         req0_valid = 1'b0, req1_valid = 1'b0;
   logic         req0_ready, req1_ready;
   logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
   logic [3:0]   req0_func = '0, req1_func = '0;
   logic         rsp0_valid, rsp1_valid;
   logic         rsp0_ready = 1'b0, rsp1_ready = 1'b0;
   logic [W-1:0] rsp_c, alu_a, alu_b, alu_c;
   logic [3:0]   alu_func, alu_psr, psr;
   logic         psr_upd, busy;
   logic [35:0]  alu_res;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   logic [3:0] exp_psr = 4'b0000;

   typedef struct {
      int          owner;
      logic [31:0] c;
      logic [3:0]  psr;
      logic        upd;
      int          acc;
   } exp_t;
   exp_t sb[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   alu_arbiter #(.W(W), .PSR_RST(4'b0000), .CC_MAXFUNC(4'd3)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_func(req0_func),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_func(req1_func),
      .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
      .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
      .rsp_c(rsp_c), .alu_a(alu_a), .alu_b(alu_b), .alu_func(alu_func),
      .alu_c(alu_c), .alu_psr(alu_psr), .psr(psr), .psr_upd(psr_upd), .busy(busy)
   );

   // Reference ARC ALU: returns {n,z,v,c, result}.
   function automatic logic [35:0] alu_ref(input logic [31:0] a, input logic [31:0] b, input logic [3:0] f);
      logic [32:0] sum;
      logic [31:0] r;
      logic v, c;
      v = 1'b0; c = 1'b0; sum = '0;
      case (f)
         F_ANDCC, F_AND: r = a & b;
         F_ORCC, F_OR:   r = a | b;
         F_NORCC, F_NOR: r = ~(a | b);
         F_ADDCC, F_ADD: begin
            sum = {1'b0, a} + {1'b0, b};
            r = sum[31:0];
            c = sum[32];
            v = (a[31] == b[31]) && (r[31] != a[31]);
         end
         F_SRL:      r = a >> b[4:0];
         F_LSHIFT2:  r = a << 2;
         F_LSHIFT10: r = a << 10;
         F_SIMM13:   r = {19'b0, a[12:0]};
         F_SEXT13:   r = {{19{a[12]}}, a[12:0]};
         F_INC:      r = a + 32'd1;
         F_INCPC:    r = a + 32'd4;
         F_RSHIFT5:  r = {{5{a[31]}}, a[31:5]};
         default:    r = '0;
      endcase
      return {r[31], (r == 32'd0), v, c, r};
   endfunction

   always_comb alu_res = alu_ref(alu_a, alu_b, alu_func);
   assign alu_c   = alu_res[31:0];
   assign alu_psr = alu_res[35:32];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic set_req(input int r, input logic [31:0] a, input logic [31:0] b, input logic [3:0] f);
      if (r == 0) begin
         req0_valid = 1'b1; req0_a = a; req0_b = b; req0_func = f;
      end else begin
         req1_valid = 1'b1; req1_a = a; req1_b = b; req1_func = f;
      end
   endtask

   task automatic grant(input int r);
      logic [31:0] a, b;
      logic [3:0]  f;
      logic [35:0] res;
      exp_t e;
      bit found;
      found = 1'b0;
      a = (r == 1) ? req1_a : req0_a;
      b = (r == 1) ? req1_b : req0_b;
      f = (r == 1) ? req1_func : req0_func;
      for (int i = 0; i < 20 && !found; i++) begin
         #1;
         if (((r == 1) ? req0_ready : req1_ready) === 1'b1)
            chk("gnt_wrong_side", {31'b0, ((r == 1) ? req0_ready : req1_ready)}, 32'd0);
         if (((r == 1) ? req1_ready : req0_ready) === 1'b1) found = 1'b1;
         else @(negedge clk);
      end
      chk("gnt_seen", {31'b0, found}, 32'd1);
      if (found) begin
         res = alu_ref(a, b, f);
         if (f <= CC_MAXFUNC) exp_psr = res[35:32];
         e.owner = r; e.c = res[31:0]; e.psr = exp_psr; e.upd = (f <= CC_MAXFUNC); e.acc = cyc;
         sb.push_back(e);
         $display("grant req%0d func=%0d a=%h b=%h exp_c=%h exp_psr=%b", r, f, a, b, e.c, e.psr);
         @(posedge clk); #1;
         if (r == 1) req1_valid = 1'b0; else req0_valid = 1'b0;
         @(negedge clk); #1;
         chk("exec_alu_a", alu_a, a);
         chk("exec_alu_b", alu_b, b);
         chk("exec_alu_func", {28'b0, alu_func}, {28'b0, f});
         chk("exec_busy", {31'b0, busy}, 32'd1);
      end
   endtask

   task automatic wait_rsp(input int r, input int hold);
      exp_t e;
      bit found;
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         #1;
         if (((r == 1) ? rsp1_valid : rsp0_valid) === 1'b1) found = 1'b1;
         else @(negedge clk);
      end
      chk("rsp_seen", {31'b0, found}, 32'd1);
      if (found && sb.size() > 0) begin
         e = sb.pop_front();
         $display("response req%0d c=%h psr=%b upd=%b", r, rsp_c, psr, psr_upd);
         chk("rsp_latency", cyc - e.acc, 32'd2);
         chk("rsp_c", rsp_c, e.c);
         chk("rsp_psr", {28'b0, psr}, {28'b0, e.psr});
         chk("rsp_psr_upd", {31'b0, psr_upd}, {31'b0, e.upd});
         chk("rsp_other_valid", {31'b0, ((r == 1) ? rsp0_valid : rsp1_valid)}, 32'd0);
         for (int h = 0; h < hold; h++) begin
            @(negedge clk); #1;
            chk("hold_valid", {31'b0, ((r == 1) ? rsp1_valid : rsp0_valid)}, 32'd1);
            chk("hold_rsp_c", rsp_c, e.c);
            chk("hold_req1_ready", {31'b0, req1_ready}, 32'd0);
            chk("hold_psr_upd", {31'b0, psr_upd}, 32'd0);
         end
         if (r == 1) rsp1_ready = 1'b1; else rsp0_ready = 1'b1;
         @(posedge clk); #1;
         rsp0_ready = 1'b0; rsp1_ready = 1'b0;
         @(negedge clk); #1;
         chk("idle_busy", {31'b0, busy}, 32'd0);
         chk("idle_rsp_valid", {31'b0, ((r == 1) ? rsp1_valid : rsp0_valid)}, 32'd0);
         chk("idle_psr_upd", {31'b0, psr_upd}, 32'd0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_psr", {28'b0, psr}, 32'd0);
      chk("rst_psr_upd", {31'b0, psr_upd}, 32'd0);
      chk("rst_rsp_c", rsp_c, 32'd0);
      chk("rst_readys", {30'b0, req1_ready, req0_ready}, 32'd0);
      chk("rst_rsp_valids", {30'b0, rsp1_valid, rsp0_valid}, 32'd0);
      chk("rst_alu_a", alu_a, 32'd0);
      chk("rst_alu_func", {28'b0, alu_func}, 32'd0);

      // Both valid from reset: order must be 0,1,0,1
      set_req(0, 32'h0, 32'h0, F_ORCC);
      set_req(1, 32'hFFFFFFFF, 32'h1, F_ADDCC);
      grant(0); wait_rsp(0, 0);
      grant(1); wait_rsp(1, 0);
      set_req(0, 32'h0, 32'h0, F_NORCC);
      set_req(1, 32'h80, 32'h4, F_SRL);
      grant(0); wait_rsp(0, 0);
      grant(1); wait_rsp(1, 0);

      // ADDCC overflow into the sign bit
      set_req(0, 32'h7FFFFFFF, 32'h1, F_ADDCC);
      grant(0); wait_rsp(0, 0);
      chk("t1_rsp_c", rsp_c, 32'h80000000);
      chk("t1_psr", {28'b0, psr}, 32'b1010);

      // Non-CC op leaves the PSR alone
      set_req(1, 32'd5, 32'd3, F_ADD);
      grant(1); wait_rsp(1, 0);
      chk("t2_rsp_c", rsp_c, 32'd8);
      chk("t2_psr", {28'b0, psr}, 32'b1010);

      // ANDCC to zero
      set_req(0, 32'hF0, 32'h0F, F_ANDCC);
      grant(0); wait_rsp(0, 0);
      chk("t4_rsp_c", rsp_c, 32'd0);
      chk("t4_psr", {28'b0, psr}, 32'b0100);

      // Backpressure on req0 while req1 waits
      set_req(0, 32'd100, 32'd23, F_ADD);
      grant(0);
      set_req(1, 32'd41, 32'd0, F_INC);
      wait_rsp(0, 10);
      chk("t5_req1_ready_after_release", {31'b0, req1_ready}, 32'd1);
      grant(1); wait_rsp(1, 0);

      // Reset in the middle of an ORCC
      set_req(0, 32'd5, 32'd0, F_ORCC);
      #1;
      chk("t6_ready", {31'b0, req0_ready}, 32'd1);
      @(posedge clk);
      @(negedge clk); #1;
      chk("t6_exec_busy", {31'b0, busy}, 32'd1);
      rst_n = 1'b0;
      req0_valid = 1'b0;
      #1;
      $display("reset during EXEC psr=%b busy=%b", psr, busy);
      chk("t6_psr", {28'b0, psr}, 32'd0);
      chk("t6_busy", {31'b0, busy}, 32'd0);
      chk("t6_rsp_c", rsp_c, 32'd0);
      chk("t6_alu_func", {28'b0, alu_func}, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      exp_psr = 4'b0000;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); #1;
         chk("t6_no_rsp", {30'b0, rsp1_valid, rsp0_valid}, 32'd0);
         chk("t6_idle", {31'b0, busy}, 32'd0);
      end

      // Recovery after reset
      set_req(1, 32'h80000000, 32'h80000000, F_ADDCC);
      grant(1); wait_rsp(1, 0);
      chk("t7_psr", {28'b0, psr}, 32'b0111);
      chk("sb_drained", sb.size(), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
